// File: rtl/fft_sdf_pkg.sv
// fft_sdf_pkg: shared helpers for the radix-2 SDF FFT stage.
//   clog2       - ceil(log2(value)) for parameter arithmetic
//   cplx_width  - packed width of a {re, im} pair of comp_width components
//   re_lsb      - bit position of the real half inside a packed pair
//   twiddle     - W^k = cos(pi*k/delay) - j*sin(pi*k/delay), scaled by
//                 2^(nc-1)-1 and rounded to nearest; elaboration-time only
//   saturate    - clamp a wide signed value into an n-bit signed range
package fft_sdf_pkg;

  localparam real PI = 3.14159265358979323846;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int cplx_width(input int comp_width);
    return 2 * comp_width;
  endfunction

  function automatic int re_lsb(input int comp_width);
    return comp_width;
  endfunction

  // Round to nearest, halves away from zero.
  function automatic int round_real(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Returns {wr, wi}, each sign-extended to 32 bits.
  function automatic logic [63:0] twiddle(input int k, input int delay, input int nc);
    real scale;
    real ang;
    int  wr;
    int  wi;
    scale = real'((1 << (nc - 1)) - 1);
    ang   = PI * real'(k) / real'(delay);
    wr    = round_real(scale * $cos(ang));
    wi    = round_real(-scale * $sin(ang));
    return {32'(wr), 32'(wi)};
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// fft_twiddle_rom: constant twiddle table for one SDF stage, purely
// combinational (no read register, the product is formed in the same cycle).
//   idx  in   KW bits           twiddle index k
//   wr   out  NBITS_COEFF bits  real part of W^k
//   wi   out  NBITS_COEFF bits  imaginary part of W^k
// The table holds 2^KW entries, which equals DELAY except for DELAY=1,
// where the extra entry is never addressed.
module fft_twiddle_rom import fft_sdf_pkg::*; #(
  parameter int DELAY       = 16,
  parameter int NBITS_COEFF = 11,
  parameter int KW          = 4
) (
  input  logic [KW-1:0]                 idx,
  output logic signed [NBITS_COEFF-1:0] wr,
  output logic signed [NBITS_COEFF-1:0] wi
);

  localparam int ENTRIES = 1 << KW;

  logic [2*NBITS_COEFF-1:0] rom [ENTRIES];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    localparam logic [63:0] TW = twiddle(gi, DELAY, NBITS_COEFF);
    assign rom[gi] = {TW[32 +: NBITS_COEFF], TW[0 +: NBITS_COEFF]};
  end

  assign {wr, wi} = rom[idx];

endmodule

// File: rtl/fft_sdf_stage.sv
// fft_sdf_stage: radix-2 single-path delay-feedback FFT stage.
// Fill half of a frame (index < DELAY): input goes into the delay line and
// the stored difference from the previous frame leaves multiplied by W^k.
// Butterfly half: head+input leaves as a sum, head-input is stored.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   sample strobe (no backpressure)
//   in_sof     in   start of frame, forces this sample to index 0
//   in_data    in   {re, im}, NBITS each
//   out_valid  out  registered output strobe
//   out_sum    out  1 = butterfly sum, 0 = twiddled difference
//   out_data   out  {re, im}, NBITS_OUT each, saturated
//   ovf        out  sticky saturation flag, present only when the macro
//                   FFT_SDF_OVF_EN is defined
module fft_sdf_stage import fft_sdf_pkg::*; #(
  parameter int NBITS       = 10,
  parameter int NBITS_COEFF = 11,
  parameter int NBITS_OUT   = 11,
  parameter int DELAY       = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic                               in_sof,
  input  logic [cplx_width(NBITS)-1:0]       in_data,
  output logic                               out_valid,
  output logic                               out_sum,
  output logic [cplx_width(NBITS_OUT)-1:0]   out_data
`ifdef FFT_SDF_OVF_EN
  ,
  output logic                               ovf
`endif
);

  localparam int CW        = clog2(2 * DELAY);
  localparam int KW        = (DELAY > 1) ? clog2(DELAY) : 1;
  localparam int BW        = NBITS + 1;
  localparam int PW        = BW + NBITS_COEFF + 1;
  localparam int IN_RE_LSB = re_lsb(NBITS);
  localparam logic signed [PW-1:0] RND = PW'(1) << (NBITS_COEFF - 2);

  logic [CW-1:0]                 cnt;
  logic [CW-1:0]                 idx;
  logic                          fill;
  logic                          primed;
  logic                          emit;
  logic [KW-1:0]                 wptr;
  logic [2*BW-1:0]               dline [DELAY];
  logic signed [BW-1:0]          a_re, a_im, b_re, b_im;
  logic signed [BW-1:0]          sum_re, sum_im, dif_re, dif_im;
  logic signed [NBITS_COEFF-1:0] wr, wi;
  logic signed [PW-1:0]          prod_re, prod_im, mul_re, mul_im;
  logic signed [63:0]            pre_re, pre_im;
  logic signed [NBITS_OUT-1:0]   sat_re, sat_im;

  // Frame index of the sample on the input this cycle.
  assign idx  = in_sof ? '0 : cnt;
  // 2*DELAY is a power of two, so the MSB separates the two halves.
  assign fill = ~idx[CW-1];
  // The sample that sets primed is already emitted.
  assign emit = primed | (idx == CW'(DELAY));

  // Circular buffer: the slot about to be overwritten holds the sample
  // written DELAY accepted samples ago, i.e. the head.
  assign {a_re, a_im} = dline[wptr];
  assign b_re = BW'(signed'(in_data[IN_RE_LSB +: NBITS]));
  assign b_im = BW'(signed'(in_data[0 +: NBITS]));

  assign sum_re = a_re + b_re;
  assign sum_im = a_im + b_im;
  assign dif_re = a_re - b_re;
  assign dif_im = a_im - b_im;

  fft_twiddle_rom #(
    .DELAY      (DELAY),
    .NBITS_COEFF(NBITS_COEFF),
    .KW         (KW)
  ) u_rom (
    .idx(idx[KW-1:0]),
    .wr (wr),
    .wi (wi)
  );

  // Full-precision complex product, then round half up back to data scale.
  assign prod_re = PW'(a_re) * PW'(wr) - PW'(a_im) * PW'(wi);
  assign prod_im = PW'(a_re) * PW'(wi) + PW'(a_im) * PW'(wr);
  assign mul_re  = (prod_re + RND) >>> (NBITS_COEFF - 1);
  assign mul_im  = (prod_im + RND) >>> (NBITS_COEFF - 1);

  assign pre_re = fill ? 64'(mul_re) : 64'(sum_re);
  assign pre_im = fill ? 64'(mul_im) : 64'(sum_im);
  assign sat_re = NBITS_OUT'(saturate(pre_re, NBITS_OUT));
  assign sat_im = NBITS_OUT'(saturate(pre_im, NBITS_OUT));

`ifdef FFT_SDF_OVF_EN
  logic clip;
  assign clip = (64'(sat_re) != pre_re) || (64'(sat_im) != pre_im);
`endif

  // Delay-line storage carries no reset; stale contents are hidden by primed.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      dline[wptr] <= fill ? {b_re, b_im} : {dif_re, dif_im};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      wptr      <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= 1'b0;
      out_data  <= '0;
`ifdef FFT_SDF_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        cnt  <= idx + CW'(1);
        wptr <= (wptr == KW'(DELAY - 1)) ? '0 : wptr + KW'(1);
        if (idx == CW'(DELAY)) primed <= 1'b1;
        out_valid <= emit;
        out_sum   <= ~fill;
        out_data  <= {sat_re, sat_im};
`ifdef FFT_SDF_OVF_EN
        // Unprimed samples come from stale storage and must not trip ovf.
        if (emit && clip) ovf <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: doc/fft_sdf_stage.md
# fft_sdf_stage

Parametrised radix-2 single-path delay-feedback (SDF) FFT stage. It carries the butterfly, the feedback delay line, counter control, twiddle multiply and output saturation as one reusable unit. A complete pipelined FFT is a chain of these stages with DELAY = N/2, N/4, …, 1. Each stage processes one complex sample per accepted cycle.

## Interface
- NBITS, 10: signed width of each input component (re, im).
- NBITS_COEFF, 11: signed twiddle component width, Q1.(NBITS_COEFF-1).
- NBITS_OUT, 11: signed width of each output component.
- DELAY, 16: feedback depth, power of 2, ≥1; frame length 2·DELAY.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample strobe; no backpressure.
- in_sof  in  1  start-of-frame, qualified by in_valid.
- in_data  in  2·NBITS  {re, im}, re in upper half.
- out_valid  out  1  output sample strobe.
- out_sum  out  1  1 = sum (upper-butterfly) sample, 0 = twiddled difference sample.
- out_data  out  2·NBITS_OUT  {re, im}, re in upper half.
- ovf  out  1  sticky saturation flag (only with FFT_SDF_OVF_EN).

## Operation
- **Sample counter.**
  - cnt, log2(2·DELAY) bits, advances by 1 per accepted sample (in_valid=1), wrapping 2·DELAY-1 → 0.
  - in_valid & in_sof forces this sample to index 0; cnt becomes 1 after it.
- **Fill phase (index < DELAY).**
  - Input is written into the delay line.
  - Delay-line head value d, the difference stored in the previous frame, goes to the output path.
  - d is multiplied by W^k, with k = index, giving out_sum=0.
- **Butterfly phase (index ≥ DELAY).**
  - a = delay-line head, b = input.
  - a+b goes to output with out_sum=1, no multiply.
  - a−b is written into the delay line.
- **Butterfly width.** NBITS+1 per component, with sign extension before the add/subtract.
- **Twiddle.**
  - W^k = cos(πk/DELAY) − j·sin(πk/DELAY), scaled by 2^(NBITS_COEFF-1)−1 and rounded to nearest.
  - W^0 re = 2^(NBITS_COEFF-1)−1, im = 0.
- **Complex multiply.**
  - Full-precision products: re = ar·wr − ai·wi, im = ar·wi + ai·wr.
  - Add 2^(NBITS_COEFF-2), then arithmetic shift right by NBITS_COEFF-1 (round half up).
- **Saturation.** Each component of either path is clamped to [−2^(NBITS_OUT-1), 2^(NBITS_OUT-1)−1].
- **Priming.**
  - A primed flag is cleared by reset.
  - It is set on the first accepted sample with index = DELAY.
  - out_valid is asserted only for samples accepted while primed, or the sample that sets it. The first fill after reset therefore emits nothing.
  - in_sof does not clear primed.

## Timing
- **Reset values.** out_valid=0, out_sum=0, out_data=0, ovf=0, cnt=0, primed=0. Delay-line contents are don't-care and are masked by primed.
- **Latency.** out_data, out_sum and out_valid are registered one clk after the accepting edge. Butterfly and multiply are combinational within that cycle.
- **Delay line.**
  - Advances only on accepted samples: a DELAY-entry shift register or circular buffer.
  - Head = sample written DELAY accepted samples earlier.
- **Gaps.** in_valid=0 → nothing advances; out_valid=0 next cycle; out_data holds its last value.
- **sof.** in_sof mid-frame truncates the current frame; delay-line contents are reused as-is.
- **Reset mid-frame.** Asynchronous return to reset values; the next frame must refill before output.

## Configuration
- **FFT_SDF_OVF_EN defined:**
  - ovf port exists.
  - It is set one clk after any accepted sample whose output clamped on either component or path.
  - It is cleared only by rst.
- **FFT_SDF_OVF_EN undefined:** ovf port and its logic are absent; saturation behaviour is unchanged.

## Structure
- **Package fft_sdf_pkg** holds:
  - the clog2 helper;
  - the complex {re,im} pack/unpack width helpers;
  - the twiddle constant function (cos/sin scaling, elaboration-time only);
  - the shared saturation function.
- **Sub-module fft_twiddle_rom** (DELAY entries, index in, registered-free combinational {wr,wi} out), built from the package function.

## Test plan
- **Reset.** Assert rst low mid-stream with in_valid=1 → all outputs 0 asynchronously. The first 4 post-reset samples (DELAY=4) give out_valid=0.
- **Impulse.**
  - Setup: DELAY=4, defaults otherwise. Frame x0=(100,0), then 15 zeros.
  - Sums: cycles 5–8 give out_sum=1 with (100,0), 0, 0, 0.
  - Differences: next 4 give out_sum=0 with (100,0), 0, 0, 0, since 100·1023 rounds to 100.
- **Twiddle.**
  - Setup: DELAY=4. First half zeros, second half constant (0,0) with a=(200,0) pre-stored.
  - Differences: index 2 → (0,−200); index 1 → (141,−141).
- **Saturation.**
  - Stimulus: x=(511,511) in both halves, NBITS_OUT=10.
  - Sum → (511,511) clamped; ovf=1 with macro; ovf port absent without.
- **Gaps.** The impulse frame with in_valid toggling 1/0 gives the same output values; out_valid only follows accepted samples.
- **sof resync.** in_sof at index 2 → next sample is treated as index 1; following sums appear after 3 more accepted samples.
